// File: rtl/nibble_port_tx.sv
// Return-path nibble transmitter: sends a word MS nibble first over a 4-bit port
// using a toggle-tag / echo-ack handshake with a synchronized host ack.
module nibble_port_tx #(
    parameter int unsigned NIBBLES      = 4,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 1000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] word,
    output logic                 ready,
    output logic                 done,
    output logic                 error,
    input  logic                 port_ack_in,
    output logic [3:0]           port_data,
    output logic                 port_tag
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int unsigned NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [SW-1:0] SetupLoad = SW'(SETUP_CYCLES - 1);
    localparam logic [NW-1:0] NibLoad   = NW'(NIBBLES - 1);
    localparam logic [31:0]   TmoLast   = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StWaitAck} state_e;

    state_e        state_q, state_d;
    logic          ack_meta_q, ack_s_q;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [3:0]    data_q, data_d;
    logic          tag_q, tag_d;
    logic [SW-1:0] setup_q, setup_d;
    logic [NW-1:0] nib_q, nib_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [W-1:0]  shifted;

    assign shifted = shreg_q << 4;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        tag_d   = tag_q;
        setup_d = setup_q;
        nib_d   = nib_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d = word;
                    data_d  = word[W-1 -: 4];
                    nib_d   = NibLoad;
                    setup_d = SetupLoad;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (setup_q == '0) begin
                    tag_d   = ~tag_q;
                    tmo_d   = '0;
                    state_d = StWaitAck;
                end else begin
                    setup_d = setup_q - 1'b1;
                end
            end
            StWaitAck: begin
                // An ack on the final timeout edge still counts as an ack.
                if (ack_s_q == tag_q) begin
                    if (nib_q == '0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        shreg_d = shifted;
                        data_d  = shifted[W-1 -: 4];
                        nib_d   = nib_q - 1'b1;
                        setup_d = SetupLoad;
                        state_d = StSetup;
                    end
                end else if ((TIMEOUT != 0) && (tmo_q == TmoLast)) begin
                    error_d = 1'b1;
                    // Retract the tag so tag == ack_s holds again in idle.
                    tag_d   = ack_s_q;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            shreg_q    <= '0;
            data_q     <= '0;
            tag_q      <= 1'b0;
            setup_q    <= '0;
            nib_q      <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_meta_q <= port_ack_in;
            ack_s_q    <= ack_meta_q;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            setup_q    <= setup_d;
            nib_q      <= nib_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ready     = (state_q == StIdle);
    assign done      = done_q;
    assign error     = error_q;
    assign port_data = data_q;
    assign port_tag  = tag_q;

endmodule

// File: tb/tb_nibble_port_tx.sv
// Directed bench for nibble_port_tx: instance 0 uses default parameters,
// instance 1 uses TIMEOUT=16. A negedge host model echoes, delays or withholds acks.
module tb_nibble_port_tx;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       start_v;
    logic [1:0][15:0] word_v;
    logic [1:0]       ack_v;
    wire  [1:0]       ready_v, done_v, error_v, tag_v;
    wire  [1:0][3:0]  data_v;
    int               mode_v [2];   // 0 hold, 1 zero-delay echo, 2 echo after 10 cycles
    int               dcnt [2];
    int               checks = 0;
    int               failures = 0;

    nibble_port_tx u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_v[0]),
        .word        (word_v[0]),
        .ready       (ready_v[0]),
        .done        (done_v[0]),
        .error       (error_v[0]),
        .port_ack_in (ack_v[0]),
        .port_data   (data_v[0]),
        .port_tag    (tag_v[0])
    );

    nibble_port_tx #(.TIMEOUT(16)) u_dut_to (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_v[1]),
        .word        (word_v[1]),
        .ready       (ready_v[1]),
        .done        (done_v[1]),
        .error       (error_v[1]),
        .port_ack_in (ack_v[1]),
        .port_data   (data_v[1]),
        .port_tag    (tag_v[1])
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (mode_v[i] == 1) begin
                ack_v[i] = tag_v[i];
            end else if (mode_v[i] == 2) begin
                if (ack_v[i] !== tag_v[i]) begin
                    dcnt[i]++;
                    if (dcnt[i] >= 10) begin
                        ack_v[i] = tag_v[i];
                        dcnt[i] = 0;
                    end
                end else begin
                    dcnt[i] = 0;
                end
            end
        end
    end

    // Full transfer with a zero-delay echo host, checked every cycle after accept edge E.
    task automatic run_xfer(input int s, input logic [15:0] w, input string name);
        logic [15:0] sh;
        logic [3:0]  exp_d;
        logic        exp_t;
        int          idx;
        int          tg;
        @(negedge clock);
        start_v[s] = 1'b1;
        word_v[s]  = w;
        @(posedge clock);
        #1;
        start_v[s] = 1'b0;
        for (int n = 0; n < 22; n++) begin
            if (n > 0) begin
                @(posedge clock);
                #1;
            end
            idx = (n / 5 > 3) ? 3 : n / 5;
            sh = w >> (12 - 4 * idx);
            exp_d = sh[3:0];
            tg = (n < 2) ? 0 : ((n - 2) / 5 + 1);
            if (tg > 4) tg = 4;
            exp_t = tg[0];
            checks++;
            if (data_v[s] !== exp_d)
                $display("FAIL %s data E+%0d got %h exp %h", name, n, data_v[s], exp_d);
            if (data_v[s] !== exp_d) failures++;
            checks++;
            if (tag_v[s] !== exp_t) begin
                $display("FAIL %s tag E+%0d got %b exp %b", name, n, tag_v[s], exp_t);
                failures++;
            end
            checks++;
            if (done_v[s] !== (n == 20)) begin
                $display("FAIL %s done E+%0d got %b exp %b", name, n, done_v[s], (n == 20));
                failures++;
            end
            checks++;
            if (ready_v[s] !== (n >= 20)) begin
                $display("FAIL %s ready E+%0d got %b exp %b", name, n, ready_v[s], (n >= 20));
                failures++;
            end
            checks++;
            if (error_v[s] !== 1'b0) begin
                $display("FAIL %s error E+%0d got %b exp 0", name, n, error_v[s]);
                failures++;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (data_v[s] !== 4'h0) begin
                $display("FAIL reset_data[%0d] got %h exp 0", s, data_v[s]);
                failures++;
            end
            checks++;
            if (tag_v[s] !== 1'b0) begin
                $display("FAIL reset_tag[%0d] got %b exp 0", s, tag_v[s]);
                failures++;
            end
            checks++;
            if (ready_v[s] !== 1'b1) begin
                $display("FAIL reset_ready[%0d] got %b exp 1", s, ready_v[s]);
                failures++;
            end
            checks++;
            if ({done_v[s], error_v[s]} !== 2'b00) begin
                $display("FAIL reset_done_error[%0d] got %b exp 00", s, {done_v[s], error_v[s]});
                failures++;
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            for (int s = 0; s < 2; s++)
                if (tag_v[s] !== 1'b0 || ready_v[s] !== 1'b1 || done_v[s] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            $display("FAIL idle_quiet bad_cycles got %0d exp 0", bad);
            failures++;
        end
    endtask

    task automatic test_delayed_echo();
        logic [3:0]  seq [$];
        logic [3:0]  prev;
        logic        ptag;
        logic [15:0] w;
        logic [15:0] sh;
        int          dones;
        int          toggles;
        int          n;
        int          after;
        w = 16'h7E81;
        dones = 0;
        toggles = 0;
        n = 0;
        after = -1;
        mode_v[0] = 2;
        @(negedge clock);
        start_v[0] = 1'b1;
        word_v[0]  = w;
        @(posedge clock);
        #1;
        start_v[0] = 1'b0;
        seq.push_back(data_v[0]);
        prev = data_v[0];
        ptag = tag_v[0];
        while (n < 400 && (after < 0 || n < after + 20)) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 30) begin
                start_v[0] = 1'b1;
                word_v[0]  = 16'h1234;
            end
            if (n == 31) start_v[0] = 1'b0;
            if (data_v[0] !== prev) begin
                seq.push_back(data_v[0]);
                prev = data_v[0];
            end
            if (tag_v[0] !== ptag) begin
                toggles++;
                ptag = tag_v[0];
            end
            if (done_v[0] === 1'b1) begin
                dones++;
                if (after < 0) after = n;
            end
        end
        checks++;
        if (after < 0) begin
            $display("FAIL delayed_done_timeout got none within %0d cycles exp one", n);
            failures++;
        end
        checks++;
        if (dones !== 1) begin
            $display("FAIL delayed_done_count got %0d exp 1", dones);
            failures++;
        end
        checks++;
        if (toggles !== 4) begin
            $display("FAIL delayed_tag_toggles got %0d exp 4", toggles);
            failures++;
        end
        checks++;
        if (seq.size() !== 4) begin
            $display("FAIL delayed_nibble_count got %0d exp 4", seq.size());
            failures++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sh = w >> (12 - 4 * i);
                checks++;
                if (seq[i] !== sh[3:0]) begin
                    $display("FAIL delayed_nibble[%0d] got %h exp %h", i, seq[i], sh[3:0]);
                    failures++;
                end
            end
        end
        mode_v[0] = 1;
    endtask

    task automatic test_timeout();
        int dones;
        dones = 0;
        mode_v[1] = 0;
        ack_v[1] = 1'b0;
        @(negedge clock);
        start_v[1] = 1'b1;
        word_v[1]  = 16'hBEEF;
        @(posedge clock);
        #1;
        start_v[1] = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            @(posedge clock);
            #1;
            if (done_v[1] === 1'b1) dones++;
            if (n == 17) begin
                checks++;
                if (error_v[1] !== 1'b0 || tag_v[1] !== 1'b1) begin
                    $display("FAIL timeout_early E+17 error/tag got %b%b exp 01",
                             error_v[1], tag_v[1]);
                    failures++;
                end
            end
            if (n == 18) begin
                checks++;
                if (error_v[1] !== 1'b1) begin
                    $display("FAIL timeout_error E+18 got %b exp 1", error_v[1]);
                    failures++;
                end
                checks++;
                if (tag_v[1] !== 1'b0 || ready_v[1] !== 1'b1) begin
                    $display("FAIL timeout_retract E+18 tag/ready got %b%b exp 01",
                             tag_v[1], ready_v[1]);
                    failures++;
                end
                checks++;
                if (data_v[1] !== 4'hB) begin
                    $display("FAIL timeout_data_hold got %h exp b", data_v[1]);
                    failures++;
                end
            end
            if (n == 19) begin
                checks++;
                if (error_v[1] !== 1'b0) begin
                    $display("FAIL timeout_pulse_width E+19 got %b exp 0", error_v[1]);
                    failures++;
                end
            end
        end
        checks++;
        if (dones !== 0) begin
            $display("FAIL timeout_no_done got %0d exp 0", dones);
            failures++;
        end
        mode_v[1] = 1;
        run_xfer(1, 16'h000F, "after_timeout");
    endtask

    task automatic test_ack_at_limit();
        int waited;
        mode_v[1] = 0;
        @(negedge clock);
        start_v[1] = 1'b1;
        word_v[1]  = 16'hC39A;
        @(posedge clock);
        #1;
        start_v[1] = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clock);
            #1;
            // Captured at E+16, ack_s high after E+17, compared at E+18 (16th wait edge).
            if (n == 15) ack_v[1] = 1'b1;
            if (n == 17) begin
                checks++;
                if (data_v[1] !== 4'hC || error_v[1] !== 1'b0) begin
                    $display("FAIL limit_pre E+17 data/error got %h/%b exp c/0",
                             data_v[1], error_v[1]);
                    failures++;
                end
            end
            if (n == 18) begin
                checks++;
                if (error_v[1] !== 1'b0) begin
                    $display("FAIL limit_no_error E+18 got %b exp 0", error_v[1]);
                    failures++;
                end
                checks++;
                if (data_v[1] !== 4'h3 || ready_v[1] !== 1'b0) begin
                    $display("FAIL limit_next_nibble E+18 data/ready got %h/%b exp 3/0",
                             data_v[1], ready_v[1]);
                    failures++;
                end
            end
        end
        mode_v[1] = 1;
        waited = 0;
        while (done_v[1] !== 1'b1 && waited < 100) begin
            @(posedge clock);
            #1;
            waited++;
        end
        checks++;
        if (done_v[1] !== 1'b1 || data_v[1] !== 4'hA) begin
            $display("FAIL limit_finish done/data got %b/%h exp 1/a after %0d cycles",
                     done_v[1], data_v[1], waited);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        mode_v[0] = 1;
        @(negedge clock);
        start_v[0] = 1'b1;
        word_v[0]  = 16'hA5C3;
        @(posedge clock);
        #1;
        start_v[0] = 1'b0;
        repeat (13) @(posedge clock);
        #1;
        checks++;
        if (data_v[0] !== 4'hC || tag_v[0] !== 1'b1) begin
            $display("FAIL midreset_pre data/tag got %h/%b exp c/1", data_v[0], tag_v[0]);
            failures++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_v[0] !== 4'h0 || tag_v[0] !== 1'b0) begin
            $display("FAIL midreset_async data/tag got %h/%b exp 0/0", data_v[0], tag_v[0]);
            failures++;
        end
        checks++;
        if (ready_v[0] !== 1'b1 || done_v[0] !== 1'b0 || error_v[0] !== 1'b0) begin
            $display("FAIL midreset_flags ready/done/error got %b%b%b exp 100",
                     ready_v[0], done_v[0], error_v[0]);
            failures++;
        end
        bad = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done_v[0] !== 1'b0) bad++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
            if (done_v[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            $display("FAIL midreset_no_done got %0d pulses exp 0", bad);
            failures++;
        end
        run_xfer(0, 16'h5A00, "post_reset");
    endtask

    initial begin
        start_v = '0;
        word_v  = '0;
        ack_v   = '0;
        for (int i = 0; i < 2; i++) begin
            mode_v[i] = 1;
            dcnt[i] = 0;
        end
        test_reset();
        run_xfer(0, 16'hA5C3, "basic");
        test_delayed_echo();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_port_tx.md
# nibble_port_tx

Transmits a multi-nibble result word from the FPGA coprocessor to the host MCU over a 4-bit parallel port. It uses a toggle-tag / echo-ack handshake, and is the return-path counterpart to the host-to-FPGA tagged data port. It sits between the coprocessor datapath, which supplies `word` and `start`, and the port_d output pins plus one host-driven ack pin. The host ack arrives asynchronously and is synchronized internally.

## Interface
- `NIBBLES`, default 4: nibbles per word; word width is 4*NIBBLES.
- `SETUP_CYCLES`, default 2 (min 1): clock edges from `port_data` change to `port_tag` toggle.
- `TIMEOUT`, default 1000000: cycles in WAIT_ACK before abort; 0 disables the timeout.

Ports:
- `clock`  in  1  single clock, all state on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transfer; honoured only while `ready`=1.
- `word`  in  4*NIBBLES  data to send; sampled on the accepting edge.
- `ready`  out  1  high iff state IDLE.
- `done`  out  1  one-cycle pulse after the last nibble is acked.
- `error`  out  1  one-cycle pulse on timeout abort.
- `port_ack_in`  in  1  host ack level, asynchronous to `clock`.
- `port_data`  out  4  current nibble.
- `port_tag`  out  1  toggles once per nibble presented.

## Operation
- Ack synchronizer: 2 flops, reset to 0; compare uses the second flop, `ack_s`.
- Handshake rule: a nibble is acknowledged when `ack_s == port_tag`. The host echoes `port_tag` onto `port_ack_in` after reading `port_data`.
- Nibble order: most significant first. The word is held in a shift register, shifted left 4 per nibble. A nibble counter is loaded with NIBBLES-1.
- IDLE:
  - `ready`=1.
  - On `start`: latch `word`, set `port_data` to the MS nibble, load the setup counter with SETUP_CYCLES-1, go to SETUP.
  - `start` in any other state is ignored (not queued).
- SETUP:
  - If the setup counter is 0: toggle `port_tag`, clear the timeout counter, go to WAIT_ACK.
  - Else decrement the setup counter.
- WAIT_ACK, ack seen:
  - If the nibble counter is 0: pulse `done`, go to IDLE.
  - Else: shift, load the next nibble into `port_data`, decrement the nibble counter, reload the setup counter, go to SETUP.
- WAIT_ACK, no ack: increment the timeout counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ack: pulse `error`, retract the tag (`port_tag` <= `ack_s`), go to IDLE.
  - Retracting keeps the invariant `port_tag == ack_s` at IDLE, so the next transfer cannot be falsely acked.
- Ack and timeout on the same edge: ack wins, no `error`.
- `port_data` holds its value after `done` or `error` until the next accepted `start`.
- `done` and `error` are never high together.

## Timing
- Reset values:
  - `port_data`=0, `port_tag`=0, `ready`=1, `done`=0, `error`=0.
  - Sync flops=0, state IDLE.
- Reset mid-transfer aborts immediately with no `done` or `error`. The host sees the tag return to 0 and must drive ack 0.
- The `start` accept edge is E. Nibble k appears at edge E+k·P, and its tag toggles at E+k·P+SETUP_CYCLES.
- With a zero-delay echoing host:
  - The ack is seen SETUP_CYCLES+3 edges after the data edge, so P = SETUP_CYCLES+3.
  - `done` is high the cycle after edge E+NIBBLES·P. With defaults that is E+20.
  - `ready` returns the same cycle `done` is high.
- `port_data` is stable from its load edge until the ack of that nibble is seen.

## Test plan
- Reset, with `port_ack_in`=0 → `port_data`=0, `port_tag`=0, `ready`=1, `done`=`error`=0; no tag activity for 100 cycles.
- `word`=0xA5C3, zero-delay echo host, defaults → `port_data` A,5,C,3 at E, E+5, E+10, E+15. `port_tag` goes 1,0,1,0 at E+2, E+7, E+12, E+17. `done` pulse after E+20; `ready`=1.
- Host delays each echo by 10 cycles; `start` with 0x1234 pulsed mid-transfer → `port_data` is constant within each nibble, 0x1234 is never sent, `done` only once.
- TIMEOUT=16, host never acks → `error` pulse 16 cycles after the first tag toggle. `port_tag` returns to 0. A following transfer of 0x000F with an echoing host completes normally (0,0,0,F).
- TIMEOUT=16, host ack lands so `ack_s` matches on the 16th WAIT_ACK edge → treated as ack, no `error`, next nibble loads.
- Assert `reset_n` low during nibble 2 of 0xA5C3 → outputs go to reset values asynchronously, no `done`. After release, 0x5A00 transfers correctly.
